// File: rtl/mmu_pkg.sv
// Shared MMU constants and the page-fill state encoding.
// Used by the cache stage and by page_fill.
package mmu_pkg;

  localparam int MMU_PAGE_BITS = 10;
  localparam int MMU_SLOT_BITS = 2;
  localparam int MMU_ADDR_W    = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_TAG   = 3'd4,
    ST_DONE  = 3'd5
  } fill_state_t;

endpackage

// File: rtl/victim_rr.sv
// Round-robin victim pointer: steps to the next cache slot on each advance,
// wrapping naturally at the top of the counter.
module victim_rr
  import mmu_pkg::*;
#(
  parameter int SLOT_BITS = MMU_SLOT_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_advance,
  output logic [SLOT_BITS-1:0] o_ptr
);

  logic [SLOT_BITS-1:0] r_ptr;

  // Pointer register with synchronous reset to slot 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= r_ptr + SLOT_BITS'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/page_fill.sv
// Page fill engine: copies one page from backing memory into a cache slot
// byte by byte, then writes the tag entry and reports completion.
module page_fill
  import mmu_pkg::*;
#(
  parameter int PAGE_BITS = MMU_PAGE_BITS,
  parameter int SLOT_BITS = MMU_SLOT_BITS
) (
  input  logic                            fpgaClk,
  input  logic                            fpgaRst,
  input  logic                            missReq,
  input  logic [MMU_ADDR_W-PAGE_BITS-1:0] missPage,
  output logic                            busy,
  output logic                            fillDone,
  output logic                            memReq,
  output logic [MMU_ADDR_W-1:0]           memAddr,
  input  logic                            memAck,
  input  logic [7:0]                      memData,
  output logic                            sramWe,
  output logic [SLOT_BITS+PAGE_BITS-1:0]  sramAddr,
  output logic [7:0]                      sramData,
  output logic                            tagWe,
  output logic [SLOT_BITS-1:0]            tagSlot,
  output logic [MMU_ADDR_W-PAGE_BITS-1:0] tagPage
);

  localparam int PN_W = MMU_ADDR_W - PAGE_BITS;

  fill_state_t                   r_state, w_state_nxt;
  logic [PN_W-1:0]               r_page, w_page_nxt;
  logic [SLOT_BITS-1:0]          r_victim, w_victim_nxt, w_rr_ptr;
  logic [PAGE_BITS-1:0]          r_offset, w_offset_nxt;
  logic                          w_advance;

  logic                          r_busy, r_fill_done, r_mem_req, r_sram_we, r_tag_we;
  logic [MMU_ADDR_W-1:0]         r_mem_addr;
  logic [SLOT_BITS+PAGE_BITS-1:0] r_sram_addr;
  logic [7:0]                    r_sram_data;
  logic [SLOT_BITS-1:0]          r_tag_slot;
  logic [PN_W-1:0]               r_tag_page;

  assign w_advance = (r_state == ST_DONE);

  victim_rr #(.SLOT_BITS(SLOT_BITS)) u_victim_rr (
    .i_clk     (fpgaClk),
    .i_rst     (fpgaRst),
    .i_advance (w_advance),
    .o_ptr     (w_rr_ptr)
  );

  // Next-state and fill-context computation
  always_comb begin
    w_state_nxt  = r_state;
    w_page_nxt   = r_page;
    w_victim_nxt = r_victim;
    w_offset_nxt = r_offset;
    case (r_state)
      ST_IDLE: begin
        if (missReq) begin
          w_state_nxt  = ST_REQ;
          w_page_nxt   = missPage;
          w_victim_nxt = w_rr_ptr;
          w_offset_nxt = '0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_REQ:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (memAck) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WRITE: begin
        // The last offset goes straight to the tag write; offset is not wrapped.
        if (&r_offset) begin
          w_state_nxt  = ST_TAG;
        end else begin
          w_state_nxt  = ST_REQ;
          w_offset_nxt = r_offset + PAGE_BITS'(1);
        end
      end
      ST_TAG:   w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State and fill-context registers
  always_ff @(posedge fpgaClk) begin
    if (fpgaRst) begin
      r_state  <= ST_IDLE;
      r_page   <= '0;
      r_victim <= '0;
      r_offset <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_page   <= w_page_nxt;
      r_victim <= w_victim_nxt;
      r_offset <= w_offset_nxt;
    end
  end

  // Outputs are registered from the next state so each lines up with its state's cycle
  always_ff @(posedge fpgaClk) begin
    if (fpgaRst) begin
      r_busy      <= 1'b0;
      r_fill_done <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_sram_we   <= 1'b0;
      r_sram_addr <= '0;
      r_sram_data <= 8'h00;
      r_tag_we    <= 1'b0;
      r_tag_slot  <= '0;
      r_tag_page  <= '0;
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_mem_req   <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT);
      r_sram_we   <= (w_state_nxt == ST_WRITE);
      r_tag_we    <= (w_state_nxt == ST_TAG);
      r_fill_done <= (w_state_nxt == ST_DONE);
      if (w_state_nxt == ST_REQ) begin
        r_mem_addr <= {w_page_nxt, w_offset_nxt};
      end
      if (w_state_nxt == ST_WRITE) begin
        r_sram_addr <= {r_victim, r_offset};
        r_sram_data <= memData;
      end
      if (w_state_nxt == ST_TAG) begin
        r_tag_slot <= r_victim;
        r_tag_page <= r_page;
      end
    end
  end

  assign busy     = r_busy;
  assign fillDone = r_fill_done;
  assign memReq   = r_mem_req;
  assign memAddr  = r_mem_addr;
  assign sramWe   = r_sram_we;
  assign sramAddr = r_sram_addr;
  assign sramData = r_sram_data;
  assign tagWe    = r_tag_we;
  assign tagSlot  = r_tag_slot;
  assign tagPage  = r_tag_page;

endmodule

// File: tb/tb_page_fill.sv
// Directed self-checking bench for page_fill: one task per scenario.
module tb_page_fill;

  logic        fpgaClk = 1'b0;
  logic        fpgaRst = 1'b1;
  logic        missReq = 1'b0;
  logic [13:0] missPage = 14'h0000;
  logic        busy, fillDone, memReq, sramWe, tagWe;
  logic [23:0] memAddr;
  logic        memAck = 1'b1;
  logic [7:0]  memData;
  logic [11:0] sramAddr;
  logic [7:0]  sramData;
  logic [1:0]  tagSlot;
  logic [13:0] tagPage;

  int n_checks = 0;
  int n_fail   = 0;

  int obs_lat, obs_we, obs_tag, obs_done, obs_addr_err, obs_we_err, obs_excl_err, obs_busy_err;
  logic [1:0]  obs_tag_slot, obs_slot;
  logic [13:0] obs_tag_page;
  logic        obs_busy_after;
  logic [7:0]  mem_model [0:4095];

  // Backing memory returns the low byte of the requested address
  assign memData = memAddr[7:0];

  always #5 fpgaClk = ~fpgaClk;

  page_fill dut (
    .fpgaClk(fpgaClk), .fpgaRst(fpgaRst), .missReq(missReq), .missPage(missPage),
    .busy(busy), .fillDone(fillDone), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .sramWe(sramWe), .sramAddr(sramAddr),
    .sramData(sramData), .tagWe(tagWe), .tagSlot(tagSlot), .tagPage(tagPage)
  );

  // Runs one fill and records what the DUT did; cnt 0 is the accept cycle.
  task automatic run_fill(input logic [13:0] page, input bit delay_ack,
                          input int abort_off, input bit pulse_mid);
    int cnt;
    int rst_at;
    bit finished;
    obs_lat = 0; obs_we = 0; obs_tag = 0; obs_done = 0;
    obs_addr_err = 0; obs_we_err = 0; obs_excl_err = 0; obs_busy_err = 0;
    obs_tag_slot = 2'd3; obs_slot = 2'd3; obs_tag_page = 14'h0000; obs_busy_after = 1'b1;
    rst_at = -1; finished = 1'b0; cnt = 0;
    @(negedge fpgaClk);
    missPage = page;
    missReq  = 1'b1;
    memAck   = delay_ack ? 1'b0 : 1'b1;
    while (!finished && cnt < 4000) begin
      @(negedge fpgaClk);
      cnt++;
      if (cnt == 1) missReq = 1'b0;
      if (delay_ack && cnt == 6) memAck = 1'b1;
      if (pulse_mid && cnt == 500) begin missReq = 1'b1; missPage = ~page; end
      if (pulse_mid && cnt == 501) begin missReq = 1'b0; missPage = page; end
      if (rst_at >= 0 && cnt == rst_at + 1) begin
        fpgaRst = 1'b0;
        obs_busy_after = busy;
      end
      if (rst_at < 0 && busy !== 1'b1) obs_busy_err++;
      if ((int'(sramWe) + int'(tagWe) + int'(fillDone) + int'(memReq)) > 1) obs_excl_err++;
      if (memReq && memAddr !== {page, obs_we[9:0]}) obs_addr_err++;
      if (sramWe) begin
        if (sramAddr[9:0] !== obs_we[9:0] || sramData !== obs_we[7:0]) obs_we_err++;
        if (obs_we == 0) obs_slot = sramAddr[11:10];
        else if (sramAddr[11:10] !== obs_slot) obs_we_err++;
        mem_model[sramAddr] = sramData;
        if (abort_off >= 0 && obs_we == abort_off) begin
          fpgaRst = 1'b1;
          rst_at  = cnt;
        end
        obs_we++;
      end
      if (tagWe) begin
        obs_tag++;
        obs_tag_slot = tagSlot;
        obs_tag_page = tagPage;
      end
      if (fillDone) begin
        obs_done++;
        obs_lat  = cnt;
        finished = 1'b1;
      end
    end
    memAck = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge fpgaClk);
    fpgaRst = 1'b1;
    repeat (2) @(negedge fpgaClk);
    fpgaRst = 1'b0;
  endtask

  task automatic test_reset();
    fpgaRst = 1'b1; missReq = 1'b1; memAck = 1'b1; missPage = 14'h0005;
    repeat (3) @(negedge fpgaClk);
    n_checks++;
    if ({busy, fillDone, memReq, memAddr, sramWe, sramAddr, sramData, tagWe, tagSlot, tagPage} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b memAddr=%h sramAddr=%h tagPage=%h expected all zero",
               busy, memAddr, sramAddr, tagPage);
    end
    missReq = 1'b0; fpgaRst = 1'b0;
    @(negedge fpgaClk);
    n_checks++;
    if (busy !== 1'b0 || memReq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b memReq=%b expected 0 0", busy, memReq);
    end
  endtask

  task automatic test_basic_fill();
    run_fill(14'h0005, 1'b0, -1, 1'b0);
    n_checks++; if (obs_lat !== 3074) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3074", obs_lat); end
    n_checks++; if (obs_we !== 1024) begin n_fail++; $display("FAIL basic_we_count: got %0d expected 1024", obs_we); end
    n_checks++; if (obs_tag !== 1) begin n_fail++; $display("FAIL basic_tag_count: got %0d expected 1", obs_tag); end
    n_checks++; if (obs_tag_slot !== 2'd0) begin n_fail++; $display("FAIL basic_tag_slot: got %0d expected 0", obs_tag_slot); end
    n_checks++; if (obs_tag_page !== 14'h0005) begin n_fail++; $display("FAIL basic_tag_page: got %h expected 0005", obs_tag_page); end
    n_checks++; if (obs_addr_err !== 0) begin n_fail++; $display("FAIL basic_mem_addr: got %0d bad cycles expected 0", obs_addr_err); end
    n_checks++; if (obs_we_err !== 0) begin n_fail++; $display("FAIL basic_sram_write: got %0d bad writes expected 0", obs_we_err); end
    n_checks++; if (obs_excl_err !== 0) begin n_fail++; $display("FAIL basic_strobe_excl: got %0d overlaps expected 0", obs_excl_err); end
    n_checks++; if (obs_busy_err !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d low cycles expected 0", obs_busy_err); end
    n_checks++; if (mem_model[12'h000] !== 8'h00) begin n_fail++; $display("FAIL basic_sram_off0: got %h expected 00", mem_model[12'h000]); end
    n_checks++; if (mem_model[12'h3FF] !== 8'hFF) begin n_fail++; $display("FAIL basic_sram_off1023: got %h expected ff", mem_model[12'h3FF]); end
    @(negedge fpgaClk);
    n_checks++; if (memAddr !== 24'h0017FF || busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got memAddr=%h busy=%b expected 0017ff 0", memAddr, busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_slot [5];
    exp_slot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_fill(14'(i + 1), 1'b0, -1, 1'b0);
      n_checks++;
      if (obs_tag_slot !== exp_slot[i] || obs_tag_page !== 14'(i + 1) || obs_lat !== 3074) begin
        n_fail++;
        $display("FAIL rr_fill%0d: got slot=%0d page=%h lat=%0d expected slot=%0d page=%h lat=3074",
                 i, obs_tag_slot, obs_tag_page, obs_lat, exp_slot[i], 14'(i + 1));
      end
    end
  endtask

  task automatic test_delayed_ack();
    run_fill(14'h0123, 1'b1, -1, 1'b0);
    n_checks++; if (obs_lat !== 3078) begin n_fail++; $display("FAIL delay_latency: got %0d expected 3078", obs_lat); end
    n_checks++; if (obs_we !== 1024 || obs_we_err !== 0) begin n_fail++; $display("FAIL delay_writes: got %0d writes %0d bad expected 1024 0", obs_we, obs_we_err); end
    n_checks++; if (obs_addr_err !== 0) begin n_fail++; $display("FAIL delay_addr_stable: got %0d bad cycles expected 0", obs_addr_err); end
    n_checks++; if (obs_excl_err !== 0) begin n_fail++; $display("FAIL delay_strobe_excl: got %0d overlaps expected 0", obs_excl_err); end
  endtask

  task automatic test_reset_mid_fill();
    run_fill(14'h0042, 1'b0, 300, 1'b0);
    n_checks++; if (obs_tag !== 0 || obs_done !== 0) begin n_fail++; $display("FAIL abort_no_tag: got tag=%0d done=%0d expected 0 0", obs_tag, obs_done); end
    n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", obs_busy_after); end
    n_checks++; if (obs_we !== 301) begin n_fail++; $display("FAIL abort_writes: got %0d expected 301", obs_we); end
    run_fill(14'h0043, 1'b0, -1, 1'b0);
    n_checks++; if (obs_tag_slot !== 2'd0 || obs_done !== 1) begin n_fail++; $display("FAIL abort_next_slot: got slot=%0d done=%0d expected 0 1", obs_tag_slot, obs_done); end
  endtask

  task automatic test_ignore();
    int stray;
    stray = 0;
    memAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge fpgaClk);
      memAck = ~memAck;
      if (busy || memReq || sramWe || tagWe || fillDone) stray++;
    end
    memAck = 1'b1;
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL idle_ack_ignored: got %0d active cycles expected 0", stray); end
    run_fill(14'h0077, 1'b0, -1, 1'b1);
    n_checks++; if (obs_done !== 1 || obs_lat !== 3074 || obs_we !== 1024) begin
      n_fail++; $display("FAIL midreq_fill: got done=%0d lat=%0d we=%0d expected 1 3074 1024", obs_done, obs_lat, obs_we);
    end
    n_checks++; if (obs_tag_page !== 14'h0077 || obs_addr_err !== 0) begin
      n_fail++; $display("FAIL midreq_page: got page=%h addr_err=%0d expected 0077 0", obs_tag_page, obs_addr_err);
    end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fpgaClk);
      if (busy || memReq || sramWe) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midreq_no_second: got %0d active cycles expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_back_to_back();
    test_delayed_ack();
    test_reset_mid_fill();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
